alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  ID/EX pipeline stage directly upstream of mainALU. Registers decoded operands, resolves
//  RAW hazards by forwarding from the EX/MEM and MEM/WB results, and selects the ALU operands:
//  A = rs1 or PC, B = rs2 or immediate. Drives inALUa/inALUb/ALUSel from registered outputs.
//  Valid/ready handshake on both sides, with flush and a saturating stall counter.
// PARAMETERS
//  XLEN   32  datapath width; must equal mainALU ALUw
//  CNTW   16  stall-counter width
// PORTS
//  clk          in   1     clock, rising edge
//  resetN       in   1     asynchronous, active-low reset
//  inValid      in   1     upstream has a decoded instruction
//  inReady      out  1     stage can accept this cycle
//  inPC         in   XLEN  instruction PC
//  inRs1Data    in   XLEN  register-file read data for rs1
//  inRs2Data    in   XLEN  register-file read data for rs2
//  inImm        in   XLEN  sign-extended immediate
//  inRs1Addr    in   5     rs1 index
//  inRs2Addr    in   5     rs2 index
//  inRdAddr     in   5     destination index
//  inASel       in   1     0: A=rs1, 1: A=PC
//  inBSel       in   1     0: B=rs2, 1: B=imm
//  inALUSel     in   4     ALU opcode (mainALU encoding), passed through
//  inRegWEn     in   1     instruction writes rd
//  flush        in   1     kill held and incoming instruction
//  exFwdWEn     in   1     EX/MEM result will be written
//  exFwdRd      in   5     EX/MEM destination
//  exFwdData    in   XLEN  EX/MEM result
//  wbFwdWEn     in   1     MEM/WB result will be written
//  wbFwdRd      in   5     MEM/WB destination
//  wbFwdData    in   XLEN  MEM/WB result
//  outValid     out  1     registered operands valid
//  outReady     in   1     downstream accepts
//  outALUa      out  XLEN  to mainALU inALUa
//  outALUb      out  XLEN  to mainALU inALUb
//  outALUSel    out  4     to mainALU ALUSel
//  outStoreData out  XLEN  forwarded rs2 (store data), independent of inBSel
//  outRdAddr    out  5     destination index
//  outRegWEn    out  1     write enable, qualified by outValid downstream
//  outPC        out  XLEN  registered PC
//  stallCnt     out  CNTW  cycles with outValid=1 and outReady=0, saturating
// BEHAVIOUR
//  - Reset (async, resetN=0): all outputs 0; outValid=0; outALUSel=4'b0000 (ADD); stallCnt=0.
//  - inReady = !outValid | outReady | flush (combinational). Accept = inValid & inReady.
//  - Latency: 1 cycle. Operands presented at edge N appear on out* after edge N.
//  - Forwarding, per source: rsAddr==0 -> 0. Else exFwdWEn & exFwdRd==rsAddr & exFwdRd!=0 ->
//    exFwdData. Else the same test on wbFwd* -> wbFwdData. Else inRsXData. EX beats WB.
//  - Operand mux after forwarding: A = inASel ? inPC : fwdRs1; B = inBSel ? inImm : fwdRs2.
//  - At each edge, flush has priority: outValid<=0 and the input is dropped, even if
//    inValid=1. Else on Accept, all out* load and outValid<=1. Else if outReady, outValid<=0.
//    Otherwise hold.
//  - Data registers change only on Accept; when outValid=0 their values are don't-care but
//    stable.
//  - Stall: outValid & !outReady holds every out* unchanged; stallCnt += 1, saturating at
//    all-ones with no wrap. A flush does not clear stallCnt; only reset does.
//  - Mid-operation reset clears outValid immediately (async). No instruction survives reset.
// TESTING
//  1. Reset, then ADD rs1=x1 (inRs1Data=5), rs2=x2 (7), no forwarding -> next cycle:
//     outALUa=5, outALUb=7, outALUSel=0, outValid=1.
//  2. rs1=x3, exFwdWEn=1/exFwdRd=3/exFwdData=0xAA, wbFwdWEn=1/wbFwdRd=3/wbFwdData=0xBB
//     -> outALUa=0xAA. With exFwdWEn=0 -> outALUa=0xBB.
//  3. rs1=x0, inRs1Data=0x1234, exFwdRd=0/exFwdWEn=1/exFwdData=9 -> outALUa=0.
//  4. inASel=1, inBSel=1, inPC=0x100, inImm=0xFFFFFFFC, inALUSel=4'b1101
//     -> outALUa=0x100, outALUb=0xFFFFFFFC, outALUSel=4'b1101.
//  5. outReady=0 for 3 cycles with outValid=1 and new inValid -> inReady=0, out* held,
//     stallCnt=3. Then outReady=1 -> next instruction loads.
//  6. flush=1 with inValid=1 while stalled -> outValid=0 next cycle. Assert resetN=0 mid-stall
//     -> outValid=0 with no clock edge.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Purpose     : bundles the operand-stage handshake, instruction fields and forwarding buses.
// Latency     : none; wires only.
// Backpressure: carries inValid/inReady upstream and outValid/outReady downstream.
// Ports: no ports; parameters XLEN (datapath width) and CNTW (stall-counter width).
//   master modport: the upstream/downstream side of the stage (decode, hazard buses, mainALU).
//   slave modport : the stage itself.
interface alu_operand_stage_if #(
   parameter int XLEN = 32,
   parameter int CNTW = 16
);
   // upstream handshake and decoded instruction
   logic            inValid;
   logic            inReady;
   logic [XLEN-1:0] inPC;
   logic [XLEN-1:0] inRs1Data;
   logic [XLEN-1:0] inRs2Data;
   logic [XLEN-1:0] inImm;
   logic [4:0]      inRs1Addr;
   logic [4:0]      inRs2Addr;
   logic [4:0]      inRdAddr;
   logic            inASel;
   logic            inBSel;
   logic [3:0]      inALUSel;
   logic            inRegWEn;
   logic            flush;
   // forwarding sources
   logic            exFwdWEn;
   logic [4:0]      exFwdRd;
   logic [XLEN-1:0] exFwdData;
   logic            wbFwdWEn;
   logic [4:0]      wbFwdRd;
   logic [XLEN-1:0] wbFwdData;
   // downstream handshake and registered operands
   logic            outValid;
   logic            outReady;
   logic [XLEN-1:0] outALUa;
   logic [XLEN-1:0] outALUb;
   logic [3:0]      outALUSel;
   logic [XLEN-1:0] outStoreData;
   logic [4:0]      outRdAddr;
   logic            outRegWEn;
   logic [XLEN-1:0] outPC;
   logic [CNTW-1:0] stallCnt;

   modport master (
      output inValid, inPC, inRs1Data, inRs2Data, inImm, inRs1Addr, inRs2Addr, inRdAddr,
             inASel, inBSel, inALUSel, inRegWEn, flush,
             exFwdWEn, exFwdRd, exFwdData, wbFwdWEn, wbFwdRd, wbFwdData, outReady,
      input  inReady, outValid, outALUa, outALUb, outALUSel, outStoreData, outRdAddr,
             outRegWEn, outPC, stallCnt
   );

   modport slave (
      input  inValid, inPC, inRs1Data, inRs2Data, inImm, inRs1Addr, inRs2Addr, inRdAddr,
             inASel, inBSel, inALUSel, inRegWEn, flush,
             exFwdWEn, exFwdRd, exFwdData, wbFwdWEn, wbFwdRd, wbFwdData, outReady,
      output inReady, outValid, outALUa, outALUb, outALUSel, outStoreData, outRdAddr,
             outRegWEn, outPC, stallCnt
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Purpose     : ID/EX stage feeding mainALU; forwards EX/MEM and MEM/WB results, muxes A/B.
// Latency     : 1 cycle from accepted input to registered out*.
// Backpressure: inReady = !outValid | outReady | flush; stalled outputs hold, stallCnt saturates.
// Ports:
//   clk    : rising-edge clock
//   resetN : asynchronous active-low reset; clears outValid and every output register
//   bus    : slave view of alu_operand_stage_if (upstream instruction, forwarding buses,
//            downstream operands, stall counter)
module alu_operand_stage #(
   parameter int XLEN = 32,
   parameter int CNTW = 16
) (
   input logic                clk,
   input logic                resetN,
   alu_operand_stage_if.slave bus
);

   logic            valid_q;
   logic [XLEN-1:0] alu_a_q;
   logic [XLEN-1:0] alu_b_q;
   logic [3:0]      alu_sel_q;
   logic [XLEN-1:0] store_q;
   logic [4:0]      rd_q;
   logic            reg_wen_q;
   logic [XLEN-1:0] pc_q;
   logic [CNTW-1:0] stall_cnt_q;

   logic            in_ready;
   logic            accept;
   logic            load;
   logic            stalled;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;

   // x0 always reads zero; the younger EX/MEM result wins over MEM/WB.
   function automatic logic [XLEN-1:0] fwd_pick(
      input logic [4:0]      addr,
      input logic [XLEN-1:0] rf_data,
      input logic            ex_wen,
      input logic [4:0]      ex_rd,
      input logic [XLEN-1:0] ex_data,
      input logic            wb_wen,
      input logic [4:0]      wb_rd,
      input logic [XLEN-1:0] wb_data
   );
      logic [XLEN-1:0] res;
      res = rf_data;
      if (addr == 5'd0) begin
         res = '0;
      end else if (ex_wen && ex_rd == addr && ex_rd != 5'd0) begin
         res = ex_data;
      end else if (wb_wen && wb_rd == addr && wb_rd != 5'd0) begin
         res = wb_data;
      end
      return res;
   endfunction

   always_comb begin
      fwd_rs1 = fwd_pick(bus.inRs1Addr, bus.inRs1Data, bus.exFwdWEn, bus.exFwdRd, bus.exFwdData,
                         bus.wbFwdWEn, bus.wbFwdRd, bus.wbFwdData);
      fwd_rs2 = fwd_pick(bus.inRs2Addr, bus.inRs2Data, bus.exFwdWEn, bus.exFwdRd, bus.exFwdData,
                         bus.wbFwdWEn, bus.wbFwdRd, bus.wbFwdData);
      op_a    = bus.inASel ? bus.inPC  : fwd_rs1;
      op_b    = bus.inBSel ? bus.inImm : fwd_rs2;
   end

   assign in_ready = !valid_q || bus.outReady || bus.flush;
   assign accept   = bus.inValid && in_ready;
   // a flushed instruction is dropped, so the data registers stay put
   assign load     = accept && !bus.flush;
   assign stalled  = valid_q && !bus.outReady;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         valid_q <= 1'b0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
      end else if (bus.outReady) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= 4'b0000;
         store_q   <= '0;
         rd_q      <= '0;
         reg_wen_q <= 1'b0;
         pc_q      <= '0;
      end else if (load) begin
         alu_a_q   <= op_a;
         alu_b_q   <= op_b;
         alu_sel_q <= bus.inALUSel;
         store_q   <= fwd_rs2;
         rd_q      <= bus.inRdAddr;
         reg_wen_q <= bus.inRegWEn;
         pc_q      <= bus.inPC;
      end
   end

   // counts every stalled edge, including one on which a flush arrives
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stall_cnt_q <= '0;
      end else if (stalled && stall_cnt_q != {CNTW{1'b1}}) begin
         stall_cnt_q <= stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   assign bus.inReady      = in_ready;
   assign bus.outValid     = valid_q;
   assign bus.outALUa      = alu_a_q;
   assign bus.outALUb      = alu_b_q;
   assign bus.outALUSel    = alu_sel_q;
   assign bus.outStoreData = store_q;
   assign bus.outRdAddr    = rd_q;
   assign bus.outRegWEn    = reg_wen_q;
   assign bus.outPC        = pc_q;
   assign bus.stallCnt     = stall_cnt_q;

endmodule
